// File: rtl/spi_lcd_sched_if.sv
// Bus bundle between the CPU/HW requesters (master) and the SPI LCD scheduler (slave).
interface spi_lcd_sched_if #(
  parameter int unsigned FIFO_AW = 3
);
  logic               cpu_we;
  logic [9:0]         cpu_wdata;
  logic               cpu_clr;
  logic               cpu_full;
  logic [FIFO_AW:0]   cpu_level;
  logic               ovf;
  logic               hw_req;
  logic [9:0]         hw_data;
  logic               hw_ack;
  logic               spi_start;
  logic [9:0]         spi_din;
  logic               busy;

  modport master (
    output cpu_we, cpu_wdata, cpu_clr, hw_req, hw_data,
    input  cpu_full, cpu_level, ovf, hw_ack, spi_start, spi_din, busy
  );

  modport slave (
    input  cpu_we, cpu_wdata, cpu_clr, hw_req, hw_data,
    output cpu_full, cpu_level, ovf, hw_ack, spi_start, spi_din, busy
  );
endinterface

// File: rtl/spi_lcd_sched.sv
// Shares the SPI LCD driver between a CPU write FIFO and a HW req/ack requester, pacing by cycles.
// Define SPI_SCHED_RR_EN for round-robin arbitration; default is fixed HW-over-CPU priority.
module spi_lcd_sched #(
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned XFER_CYCLES = 460,
  parameter int unsigned PWR_CYCLES  = 2
) (
  input logic            clk,
  input logic            reset_,
  spi_lcd_sched_if.slave bus
);
  localparam int unsigned DEPTH    = 1 << FIFO_AW;
  localparam int unsigned HOLD_MAX = (XFER_CYCLES > PWR_CYCLES) ? XFER_CYCLES : PWR_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  state_e               state_q;
  logic [9:0]           mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     level_q;
  logic                 ovf_q;
  logic                 hw_ack_q;
  logic                 spi_start_q;
  logic [9:0]           spi_din_q;
  logic                 busy_q;
  logic                 grant_hw_q;
  logic [HOLD_W-1:0]    hold_q;

  logic fifo_empty, fifo_full, pop, push, drop, pick_hw;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == (FIFO_AW+1)'(DEPTH));
  // The head word was already latched into spi_din in IDLE, so its slot is free during ISSUE.
  assign pop  = (state_q == StIssue) && !grant_hw_q;
  assign push = bus.cpu_we && (!fifo_full || pop);
  assign drop = bus.cpu_we && !push;

`ifdef SPI_SCHED_RR_EN
  logic last_hw_q;

  assign pick_hw = bus.hw_req && (fifo_empty || !last_hw_q);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      last_hw_q <= 1'b0;
    end else if (state_q == StIssue) begin
      last_hw_q <= grant_hw_q;
    end
  end
`else
  assign pick_hw = bus.hw_req;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (push && !pop) begin
        level_q <= level_q + (FIFO_AW+1)'(1);
      end else if (pop && !push) begin
        level_q <= level_q - (FIFO_AW+1)'(1);
      end
      // A drop wins over a clear in the same cycle.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.cpu_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= StIdle;
      hw_ack_q    <= 1'b0;
      spi_start_q <= 1'b0;
      spi_din_q   <= '0;
      busy_q      <= 1'b0;
      grant_hw_q  <= 1'b0;
      hold_q      <= '0;
    end else begin
      spi_start_q <= 1'b0;
      hw_ack_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.hw_req || !fifo_empty) begin
            grant_hw_q  <= pick_hw;
            spi_din_q   <= pick_hw ? bus.hw_data : mem_q[rd_ptr_q];
            spi_start_q <= 1'b1;
            hw_ack_q    <= pick_hw;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          hold_q  <= spi_din_q[9] ? HOLD_W'(PWR_CYCLES) : HOLD_W'(XFER_CYCLES);
          state_q <= StHold;
        end
        StHold: begin
          if (hold_q <= HOLD_W'(1)) begin
            hold_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cpu_full  = fifo_full;
  assign bus.cpu_level = level_q;
  assign bus.ovf       = ovf_q;
  assign bus.hw_ack    = hw_ack_q;
  assign bus.spi_start = spi_start_q;
  assign bus.spi_din   = spi_din_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_lcd_sched.sv
// Self-checking bench for spi_lcd_sched: vector table of single CPU words plus hand sequences,
// with a scoreboard queue of expected spi_din words popped on every spi_start pulse.
module tb_spi_lcd_sched;
  localparam int unsigned FIFO_AW = 3;
  localparam int unsigned XFER    = 460;
  localparam int unsigned PWR     = 2;

  logic clk    = 1'b0;
  logic reset_ = 1'b0;

  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int start_cnt  = 0;
  int ack_cnt    = 0;
  int prev_start = 0;
  int last_start = 0;

  logic [9:0] exp_q [$];

  typedef struct {
    logic [9:0]  wdata;
    int unsigned hold;
  } vec_t;

  vec_t vecs [5];

  spi_lcd_sched_if #(.FIFO_AW(FIFO_AW)) bus ();

  spi_lcd_sched #(
    .FIFO_AW    (FIFO_AW),
    .XFER_CYCLES(XFER),
    .PWR_CYCLES (PWR)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .bus   (bus)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor, sampling on the inactive edge.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (reset_ && bus.hw_ack) ack_cnt++;
      if (reset_ && bus.spi_start) begin
        start_cnt++;
        prev_start = last_start;
        last_start = cyc;
        check("sb_pending", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_din", bus.spi_din, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [9:0] w, input bit expect_it);
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = w;
    if (expect_it) exp_q.push_back(w);
    step();
    bus.cpu_we = 1'b0;
  endtask

  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (!bus.spi_start && n < limit) begin
      step();
      n++;
    end
    check("start_timeout", bus.spi_start, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((bus.busy || bus.cpu_level != 0) && n < limit) begin
      step();
      n++;
    end
    check("idle_timeout", (bus.busy || bus.cpu_level != 0), 0);
  endtask

  initial begin
    int n;
    int bn;
    int s0;
    int a0;

    vecs[0] = '{10'h0AF, XFER};
    vecs[1] = '{10'h200, PWR};
    vecs[2] = '{10'h1A5, XFER};
    vecs[3] = '{10'h3FF, PWR};
    vecs[4] = '{10'h000, XFER};

    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = '0;
    bus.cpu_clr   = 1'b0;
    bus.hw_req    = 1'b0;
    bus.hw_data   = '0;

    // Reset state
    #2;
    check("rst_spi_start", bus.spi_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_level", bus.cpu_level, 0);
    check("rst_full", bus.cpu_full, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_hw_ack", bus.hw_ack, 0);
    check("rst_din", bus.spi_din, 0);
    repeat (3) step();
    reset_ = 1'b1;
    repeat (2) step();

    // Single CPU words: latency, pop timing, busy length and held din
    for (int i = 0; i < 5; i++) begin
      write(vecs[i].wdata, 1'b1);
      check("vec_level_pre", bus.cpu_level, 1);
      wait_start(10, n);
      check("vec_latency", n, 1);
      bn = 0;
      while (bus.busy && bn < 1000) begin
        bn++;
        step();
        if (bn == 1) check("vec_level_post", bus.cpu_level, 0);
      end
      check("vec_busy_len", bn, 1 + vecs[i].hold);
      check("vec_din_held", bus.spi_din, vecs[i].wdata);
    end

    // Power word then data word back to back
    write(10'h200, 1'b1);
    write(10'h1A5, 1'b1);
    wait_idle(1500);
    check("pwr_spacing", last_start - prev_start, PWR + 2);
    check("second_din8", bus.spi_din[8], 1);

    // Fill to full during HOLD, overflow, clear, push-with-pop while full
    write(10'h0F3, 1'b1);
    wait_start(10, n);
    step();
    for (int i = 0; i < 8; i++) write(10'h200 | 10'(i), 1'b1);
    check("full_level", bus.cpu_level, 8);
    check("full_flag", bus.cpu_full, 1);
    check("full_ovf_clear", bus.ovf, 0);
    write(10'h3EE, 1'b0);
    check("drop_ovf", bus.ovf, 1);
    check("drop_level", bus.cpu_level, 8);
    bus.cpu_clr = 1'b1;
    write(10'h3ED, 1'b0);
    bus.cpu_clr = 1'b0;
    check("clr_with_drop_ovf", bus.ovf, 1);
    bus.cpu_clr = 1'b1;
    step();
    bus.cpu_clr = 1'b0;
    check("clr_ovf", bus.ovf, 0);
    wait_start(600, n);
    check("issue_full_level", bus.cpu_level, 8);
    write(10'h2AB, 1'b1);
    check("pushpop_level", bus.cpu_level, 8);
    check("pushpop_full", bus.cpu_full, 1);
    check("pushpop_ovf", bus.ovf, 0);
    wait_idle(300);

    // HW and CPU both pending in IDLE: HW first with ack, then CPU word
    write(10'h011, 1'b1);
    wait_start(10, n);
    step();
    a0 = ack_cnt;
    exp_q.push_back(10'h055);
    bus.hw_data = 10'h055;
    bus.hw_req  = 1'b1;
    write(10'h0AA, 1'b1);
    wait_start(600, n);
    check("arb_hw_ack", bus.hw_ack, 1);
    check("arb_first_din", bus.spi_din, 10'h055);
    bus.hw_req = 1'b0;
    wait_idle(1500);
    check("arb_ack_count", ack_cnt - a0, 1);
    check("arb_last_din", bus.spi_din, 10'h0AA);

    // One-cycle hw_req pulse during HOLD is ignored
    write(10'h0F0, 1'b1);
    wait_start(10, n);
    step();
    s0 = start_cnt;
    a0 = ack_cnt;
    repeat (5) step();
    bus.hw_data = 10'h1FF;
    bus.hw_req  = 1'b1;
    step();
    bus.hw_req = 1'b0;
    wait_idle(600);
    repeat (5) step();
    check("pulse_no_start", start_cnt - s0, 0);
    check("pulse_no_ack", ack_cnt - a0, 0);

    // Asynchronous reset mid-HOLD with a full, overflowed FIFO
    write(10'h0AF, 1'b1);
    wait_start(10, n);
    repeat (10) step();
    for (int i = 0; i < 9; i++) write(10'h100 | 10'(i), 1'b0);
    check("pre_rst_ovf", bus.ovf, 1);
    check("pre_rst_busy", bus.busy, 1);
    #1;
    reset_ = 1'b0;
    #1;
    check("arst_spi_start", bus.spi_start, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_level", bus.cpu_level, 0);
    check("arst_full", bus.cpu_full, 0);
    check("arst_ovf", bus.ovf, 0);
    check("arst_din", bus.spi_din, 0);
    s0 = start_cnt;
    step();
    reset_ = 1'b1;
    repeat (5) step();
    check("post_rst_no_start", start_cnt - s0, 0);
    check("post_rst_idle", bus.busy, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
